// File: rtl/dlx_pkg.sv
// rtl/dlx_pkg.sv - DLX opcode constants, field positions, loader types and instruction encoder
package dlx_pkg;

    localparam logic [5:0] RTYPE_OP   = 6'h00;
    localparam logic [5:0] JTYPE_J    = 6'h02;
    localparam logic [5:0] JTYPE_JAL  = 6'h03;
    localparam logic [5:0] ITYPE_BEQZ = 6'h04;
    localparam logic [5:0] ITYPE_BNEZ = 6'h05;
    localparam logic [5:0] ITYPE_JR   = 6'h12;
    localparam logic [5:0] ITYPE_JALR = 6'h13;
    localparam logic [5:0] ITYPE_NOP  = 6'h15;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS1_MSB    = 25;
    localparam int RS1_LSB    = 21;
    localparam int RS2_MSB    = 20;
    localparam int RS2_LSB    = 16;
    localparam int RD_R_MSB   = 15;
    localparam int RD_R_LSB   = 11;
    localparam int RD_I_MSB   = 20;
    localparam int RD_I_LSB   = 16;
    localparam int FUNC_MSB   = 10;
    localparam int IMM16_MSB  = 15;
    localparam int IMM26_MSB  = 25;

    localparam logic [31:0] NOP_WORD = {ITYPE_NOP, 26'd0};

    typedef enum logic [1:0] {INSTR_R, INSTR_I, INSTR_J} instr_type_enum;

    typedef enum logic [2:0] {ST_LOAD, ST_DRAIN, ST_RELEASE, ST_RUN, ST_ERROR} loader_state_t;

    function automatic instr_type_enum instr_type(input logic [5:0] op);
        if (op == RTYPE_OP)                        return INSTR_R;
        else if (op == JTYPE_J || op == JTYPE_JAL) return INSTR_J;
        else                                       return INSTR_I;
    endfunction

    function automatic logic is_ctrl_flow(input logic [5:0] op);
        return (op == JTYPE_J)    || (op == JTYPE_JAL)  || (op == ITYPE_BEQZ) ||
               (op == ITYPE_BNEZ) || (op == ITYPE_JR)   || (op == ITYPE_JALR);
    endfunction

    function automatic logic [31:0] encode_instr(
        input logic [5:0]  op,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [4:0]  rd,
        input logic [25:0] imm,
        input logic [10:0] func
    );
        logic [31:0] w;
        w = '0;
        w[OPCODE_MSB:OPCODE_LSB] = op;
        case (instr_type(op))
            INSTR_R: begin
                w[RS1_MSB:RS1_LSB]   = rs1;
                w[RS2_MSB:RS2_LSB]   = rs2;
                w[RD_R_MSB:RD_R_LSB] = rd;
                w[FUNC_MSB:0]        = func;
            end
            INSTR_J: w[IMM26_MSB:0] = imm;
            default: begin
                w[RS1_MSB:RS1_LSB]   = rs1;
                w[RD_I_MSB:RD_I_LSB] = rd;
                w[IMM16_MSB:0]       = imm[IMM16_MSB:0];
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dlx_loader_fifo.sv
// rtl/dlx_loader_fifo.sv - synchronous FIFO for encoded words; full/empty are registered
module dlx_loader_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset: empty_q guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/dlx_prog_loader.sv
// rtl/dlx_prog_loader.sv - encodes DLX commands, writes IRAM, then releases CPU; DLX_LOADER_NOP_PAD_EN adds branch-delay NOPs
module dlx_prog_loader
    import dlx_pkg::*;
#(
    parameter int IRAM_DEPTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int NOP_PAD    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [5:0]                    cmd_opcode,
    input  logic [4:0]                    cmd_rs1,
    input  logic [4:0]                    cmd_rs2,
    input  logic [4:0]                    cmd_rd,
    input  logic [25:0]                   cmd_imm,
    input  logic [10:0]                   cmd_func,
    input  logic                          cmd_last,
    output logic                          mem_we,
    input  logic                          mem_ready,
    output logic [$clog2(IRAM_DEPTH)-1:0] mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          cpu_rst_n,
    output logic                          load_done,
    output logic [$clog2(IRAM_DEPTH):0]   instr_count,
    output logic                          overflow_err
);
    localparam int AW = $clog2(IRAM_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(NOP_PAD + 1) + 1;

    loader_state_t state_q, state_d;
    logic          rel_cnt_q, rel_cnt_d;
    logic          armed_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [CW-1:0] count_q, issued_q;
    logic          ovf_q;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]   fifo_wdata, fifo_rdata, cmd_word;
    logic          accept, pop_ovf, wr_acc, go_drain;
    logic [PW-1:0] pad_cnt_q;
    logic          pad_busy, pad_push;

    assign accept   = cmd_valid && cmd_ready;
    assign wr_acc   = mem_we_q && mem_ready;
    assign pad_busy = |pad_cnt_q;
    assign cmd_word = encode_instr(cmd_opcode, cmd_rs1, cmd_rs2, cmd_rd, cmd_imm, cmd_func);

`ifdef DLX_LOADER_NOP_PAD_EN
    logic [PW-1:0] pad_cnt_d;
    logic          pad_last_q, pad_last_d;
    logic          pad_start;

    assign pad_start = accept && is_ctrl_flow(cmd_opcode) && (NOP_PAD > 0);

    always_comb begin
        pad_cnt_d  = pad_cnt_q;
        pad_last_d = pad_last_q;
        pad_push   = 1'b0;
        if (pad_start) begin
            pad_cnt_d  = PW'(NOP_PAD);
            pad_last_d = cmd_last;
        end else if (pad_busy && !fifo_full && state_q == ST_LOAD) begin
            pad_push  = 1'b1;
            pad_cnt_d = pad_cnt_q - PW'(1);
        end
    end

    // A padded last instruction only hands over to DRAIN once its final NOP is queued.
    assign go_drain = (accept && cmd_last && !pad_start) ||
                      (pad_push && pad_cnt_q == PW'(1) && pad_last_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pad_cnt_q  <= '0;
            pad_last_q <= 1'b0;
        end else begin
            pad_cnt_q  <= pad_cnt_d;
            pad_last_q <= pad_last_d;
        end
    end
`else
    assign pad_cnt_q = '0;
    assign pad_push  = 1'b0;
    assign go_drain  = accept && cmd_last;
`endif

    assign fifo_push  = accept || pad_push;
    assign fifo_wdata = pad_push ? NOP_WORD : cmd_word;
    assign fifo_pop   = !fifo_empty && (!mem_we_q || mem_ready) && (state_q != ST_ERROR);
    // issued_q counts words already handed to the write port, so a full IRAM is caught before the address wraps.
    assign pop_ovf    = fifo_pop && (issued_q == CW'(IRAM_DEPTH));

    dlx_loader_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        rel_cnt_d = 1'b0;
        cmd_ready = 1'b0;
        cpu_rst_n = 1'b0;
        load_done = 1'b0;
        case (state_q)
            ST_LOAD: begin
                cmd_ready = armed_q && !fifo_full && !pad_busy;
                if (go_drain) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && (!mem_we_q || mem_ready)) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                rel_cnt_d = 1'b1;
                if (rel_cnt_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                cpu_rst_n = 1'b1;
                load_done = 1'b1;
            end
            default: ;
        endcase
        if (pop_ovf) state_d = ST_ERROR;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_LOAD;
            rel_cnt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rel_cnt_q <= rel_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            armed_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            if (fifo_pop && !pop_ovf) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= fifo_rdata;
                issued_q    <= issued_q + CW'(1);
            end else if (wr_acc) begin
                mem_we_q <= 1'b0;
            end
            if (wr_acc) begin
                mem_addr_q <= mem_addr_q + AW'(1);
                count_q    <= count_q + CW'(1);
            end
            if (pop_ovf) ovf_q <= 1'b1;
        end
    end

    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign instr_count  = count_q;
    assign overflow_err = ovf_q;

endmodule
